// File: rtl/bcd_cnt_7seg_if.sv
// Control/status bundle for the BCD counter: enable, direction, load strobe and
// value in; count, 7-segment pattern, tick and wrap out.
interface bcd_cnt_7seg_if #(
  parameter int DIGITS = 4
);
  logic                  i_en;
  logic                  i_up;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_val;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [8*DIGITS-1:0]   o_seg;
  logic                  o_tick;
  logic                  o_wrap;

  modport master (
    output i_en, i_up, i_load, i_load_val,
    input  o_bcd, o_seg, o_tick, o_wrap
  );

  modport slave (
    input  i_en, i_up, i_load, i_load_val,
    output o_bcd, o_seg, o_tick, o_wrap
  );
endinterface

// File: rtl/bcd_cnt_7seg.sv
// Prescaled up/down BCD counter with per-digit active-low 7-segment decode.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).

// One decimal digit: load, carry/borrow propagation and segment decode.
module bcd_cnt_7seg_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] q,
  output logic       cout,
  output logic [7:0] seg
);
  always_ff @(posedge clk) begin
    if (rst)
      q <= 4'd0;
    else if (load)
      q <= (load_nib > 4'd9) ? 4'd0 : load_nib;
    else if (cin) begin
      // Out-of-range values fold to the wrap target so a nibble can never exceed 9.
      if (up)
        q <= (q >= 4'd9) ? 4'd0 : q + 4'd1;
      else
        q <= (q == 4'd0 || q > 4'd9) ? 4'd9 : q - 4'd1;
    end
  end

  assign cout = cin & (up ? (q == 4'd9) : (q == 4'd0));

  always_comb begin
    seg = 8'hFF;
    case (q)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  end
endmodule

module bcd_cnt_7seg #(
  parameter int DIGITS = 4,
  parameter int DIV_BY = 50_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bcd_cnt_7seg_if.slave   bus
);
  localparam int PW = (DIV_BY > 1) ? $clog2(DIV_BY) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV_BY - 1);

  logic [PW-1:0]              presc;
  logic                       tick;
  logic                       step;
  logic [DIGITS:0]            carry;
  logic [DIGITS-1:0][3:0]     dig;
  logic [DIGITS-1:0][3:0]     ld_nib;
  logic [DIGITS-1:0][7:0]     raw_seg;
  logic [DIGITS-1:0][7:0]     seg;
  logic                       wrap_q;

  // Free-running prescaler; only reset and load restart its phase.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      presc <= '0;
    else if (bus.i_load || tick)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  assign tick     = (presc == PRE_MAX);
  assign step     = tick & bus.i_en & ~bus.i_load;
  assign carry[0] = step;
  assign ld_nib   = bus.i_load_val;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      bcd_cnt_7seg_digit u_dig (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (bus.i_load),
        .load_nib (ld_nib[k]),
        .cin      (carry[k]),
        .up       (bus.i_up),
        .q        (dig[k]),
        .cout     (carry[k+1]),
        .seg      (raw_seg[k])
      );
    end
  endgenerate

`ifdef LEAD_ZERO_BLANK_EN
  // hi_zero[k]: digit k and every digit above it are zero.
  logic [DIGITS:0] hi_zero;
  assign hi_zero[DIGITS] = 1'b1;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_blank
      assign hi_zero[k] = hi_zero[k+1] & (dig[k] == 4'd0);
      if (k == 0) begin : g_lsd
        assign seg[k] = raw_seg[k];
      end else begin : g_hsd
        assign seg[k] = hi_zero[k] ? 8'hFF : raw_seg[k];
      end
    end
  endgenerate
`else
  assign seg = raw_seg;
`endif

  // Carry out of the top digit is exactly a full-range wrap in either direction.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      wrap_q <= 1'b0;
    else
      wrap_q <= carry[DIGITS];
  end

  assign bus.o_bcd  = dig;
  assign bus.o_seg  = seg;
  assign bus.o_tick = tick;
  assign bus.o_wrap = wrap_q;
endmodule

// File: tb/tb_bcd_cnt_7seg.sv
// Bench for bcd_cnt_7seg (DIGITS=2, DIV_BY=4): integer reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bcd_cnt_7seg;
  localparam int DIG = 2;
  localparam int DIV = 4;
  localparam int MOD = 100;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;
  int   t;

  bcd_cnt_7seg_if #(.DIGITS(DIG)) bus ();

  bcd_cnt_7seg #(.DIGITS(DIG), .DIV_BY(DIV)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference: the count as a plain integer 0..99, prescaler as an integer phase.
  int m_val = 0;
  int m_pre = 0;
  bit m_wrap = 1'b0;

  function automatic int sanitize(input logic [7:0] v);
    int lo, hi;
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    return hi * 10 + lo;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_val <= 0; m_pre <= 0; m_wrap <= 1'b0;
    end else if (bus.i_load) begin
      m_val <= sanitize(bus.i_load_val); m_pre <= 0; m_wrap <= 1'b0;
    end else begin
      m_pre <= (m_pre == DIV - 1) ? 0 : m_pre + 1;
      if (m_pre == DIV - 1 && bus.i_en) begin
        if (bus.i_up) begin
          m_val <= (m_val + 1) % MOD; m_wrap <= (m_val == MOD - 1);
        end else begin
          m_val <= (m_val + MOD - 1) % MOD; m_wrap <= (m_val == 0);
        end
      end else
        m_wrap <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]  e_bcd;
  logic [15:0] e_seg;
  always @(negedge clk) begin
    if (chk_en) begin
      e_bcd = {4'(m_val / 10), 4'(m_val % 10)};
      e_seg = {lut[m_val / 10], lut[m_val % 10]};
`ifdef LEAD_ZERO_BLANK_EN
      if (m_val < 10) e_seg[15:8] = 8'hFF;
`endif
      check("mdl_bcd",  bus.o_bcd,  e_bcd);
      check("mdl_seg",  bus.o_seg,  e_seg);
      check("mdl_tick", bus.o_tick, (m_pre == DIV - 1));
      check("mdl_wrap", bus.o_wrap, m_wrap);
    end
  end

  // Advance n cycles; ends 1 time unit after a falling edge, where inputs are driven.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_count(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.o_tick) ticks++;
    end
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.i_load = 1'b1; bus.i_load_val = v;
    cyc(1);
    bus.i_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_up = 1'b1; bus.i_load = 1'b0; bus.i_load_val = '0;
    cyc(2);
    chk_en = 1'b1;
    check("rst_bcd",  bus.o_bcd,  8'h00);
    check("rst_wrap", bus.o_wrap, 1'b0);
    check("rst_tick", bus.o_tick, 1'b0);
`ifdef LEAD_ZERO_BLANK_EN
    check("rst_seg",  bus.o_seg,  16'hFFC0);
`else
    check("rst_seg",  bus.o_seg,  16'hC0C0);
`endif

    // Count up 40 cycles: 10 ticks, 00..10 with the 09->10 carry
    rst = 1'b0; bus.i_en = 1'b1; bus.i_up = 1'b1;
    run_count(40, t);
    check("up40_ticks", t, 10);
    check("up40_bcd", bus.o_bcd, 8'h10);

    // 98 -> 99 -> 00 with a single-cycle wrap
    load(8'h98);
    check("ld98_bcd", bus.o_bcd, 8'h98);
    cyc(4); check("up_99", bus.o_bcd, 8'h99); check("up_99_wrap", bus.o_wrap, 1'b0);
    cyc(4); check("up_00", bus.o_bcd, 8'h00); check("up_00_wrap", bus.o_wrap, 1'b1);
    cyc(1); check("up_wrap_clr", bus.o_wrap, 1'b0);

    // Down from 00 wraps to 99, then 98
    bus.i_up = 1'b0;
    load(8'h00);
    cyc(4); check("dn_99", bus.o_bcd, 8'h99); check("dn_99_wrap", bus.o_wrap, 1'b1);
    cyc(4); check("dn_98", bus.o_bcd, 8'h98); check("dn_98_wrap", bus.o_wrap, 1'b0);

    // Direction flip applies on the next step
    bus.i_up = 1'b1;
    cyc(4); check("flip_99", bus.o_bcd, 8'h99);

    // Load A7 -> 07, prescaler restarts
    load(8'hA7);
    check("ldA7_bcd", bus.o_bcd, 8'h07);
    check("ldA7_tick0", bus.o_tick, 1'b0);
    cyc(2); check("ldA7_tick2", bus.o_tick, 1'b0);
    cyc(1); check("ldA7_tick3", bus.o_tick, 1'b1);
    cyc(1); check("ldA7_step", bus.o_bcd, 8'h08);

    // Paused over 3 ticks
    bus.i_en = 1'b0;
    run_count(12, t);
    check("pause_ticks", t, 3);
    check("pause_bcd", bus.o_bcd, 8'h08);

    // Invalid nibbles load as zero
    load(8'hAB); check("ldAB_bcd", bus.o_bcd, 8'h00);
    load(8'h5C); check("ld5C_bcd", bus.o_bcd, 8'h50);
    check("ld5C_seg", bus.o_seg, 16'h92C0);

    load(8'h05);
`ifdef LEAD_ZERO_BLANK_EN
    check("seg_05", bus.o_seg, 16'hFF92);
`else
    check("seg_05", bus.o_seg, 16'hC092);
`endif

    // Reset mid-count, then first tick DIV-1 cycles after release
    bus.i_en = 1'b1; bus.i_up = 1'b1;
    cyc(5); check("pre_rst_bcd", bus.o_bcd, 8'h06);
    rst = 1'b1;
    cyc(1); check("mid_rst_bcd", bus.o_bcd, 8'h00); check("mid_rst_tick", bus.o_tick, 1'b0);
    rst = 1'b0;
    cyc(2); check("rel_tick2", bus.o_tick, 1'b0);
    cyc(1); check("rel_tick3", bus.o_tick, 1'b1);

    // Load on a tick edge wins over the step and its wrap
    load(8'h99);
    check("ld_pri_bcd", bus.o_bcd, 8'h99); check("ld_pri_wrap", bus.o_wrap, 1'b0);
    cyc(4); check("ld_pri_00", bus.o_bcd, 8'h00); check("ld_pri_00_wrap", bus.o_wrap, 1'b1);

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_cnt_7seg.md
BCD_CNT_7SEG -- requirements
Module: bcd_cnt_7seg

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have parameter DIV_BY, default 50_000_000, clock cycles per count step (legal range >= 1).
REQ-003 The block SHALL have port i_clk, input, 1 bit, system clock; all logic is in this single clock domain.
REQ-004 The block SHALL have port i_rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port i_en, input, 1 bit, count enable; 0 pauses counting and 1 counts.
REQ-006 The block SHALL have port i_up, input, 1 bit, direction; 1 counts up and 0 counts down.
REQ-007 The block SHALL have port i_load, input, 1 bit, synchronous load strobe.
REQ-008 The block SHALL have port i_load_val, input, 4*DIGITS bits, BCD load value with digit 0 in bits [3:0].
REQ-009 The block SHALL have port o_bcd, output, 4*DIGITS bits, current BCD count with digit 0 in bits [3:0].
REQ-010 The block SHALL have port o_seg, output, 8*DIGITS bits, active-low segments, digit k at [8k+7:8k], bit0..6 = a..g, bit7 = dp.
REQ-011 The block SHALL have port o_tick, output, 1 bit, prescaler tick, high 1 cycle every DIV_BY cycles.
REQ-012 The block SHALL have port o_wrap, output, 1 bit, 1-cycle pulse on full-range wrap.

Function
REQ-013 The prescaler SHALL count 0..DIV_BY-1 free-running, independent of i_en, and wrap to 0.
REQ-014 o_tick SHALL be combinational, high exactly when prescaler == DIV_BY-1; DIV_BY=1 gives o_tick constantly 1.
REQ-015 A count step SHALL occur on the clock edge where o_tick=1 and i_en=1 and i_load=0; o_bcd updates at that edge (1-cycle latency).
REQ-016 Up step SHALL be a decimal increment with per-digit carry 9->0; all-9s -> all-0s.
REQ-017 Down step SHALL be a decimal decrement with per-digit borrow 0->9; all-0s -> all-9s.
REQ-018 o_wrap SHALL be registered, high for the one cycle following an all-9s->0 (up) or all-0s->all-9s (down) step, else 0.
REQ-019 i_load=1 SHALL, at that edge, load o_bcd from i_load_val, reset the prescaler to 0, and suppress any step and o_wrap; priority is i_rst > i_load > step.
REQ-020 A load nibble > 9 SHALL load that digit as 0; other digits are unaffected.
REQ-021 A change of i_up SHALL take effect on the next step only; there is no glitch on the current value.
REQ-022 o_seg SHALL be combinational from o_bcd: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex); dp is always 1 (off).
REQ-023 o_bcd SHALL never hold a nibble > 9.

Reset
REQ-024 While i_rst=1 at a clock edge, the prescaler SHALL be cleared to 0, o_bcd to 0, and o_wrap to 0; i_load and steps are ignored.
REQ-025 After reset, o_seg SHALL show all C0 (or per REQ-027), and the first o_tick SHALL occur DIV_BY-1 cycles after reset release.
REQ-026 A reset asserted mid-count SHALL take effect on the next edge regardless of the prescaler phase.

Configuration
REQ-027 With macro LEAD_ZERO_BLANK_EN defined, the block SHALL drive 8'hFF (blank) for each digit k>0 that is 0 and has all higher digits 0; digit 0 is never blanked.
REQ-028 Without LEAD_ZERO_BLANK_EN, all digits SHALL always be decoded per REQ-022; o_bcd behaviour is identical in both builds.

Verification
REQ-029 The bench SHALL cover this case (DIGITS=2, DIV_BY=4): reset, i_en=1, i_up=1, run 40 cycles -> o_tick every 4th cycle, and o_bcd 00,01,...,09,10, where 09->10 carries.
REQ-030 The bench SHALL cover this case: load 8'h98, up -> 99 then 00, with o_wrap=1 for exactly 1 cycle after 00 appears.
REQ-031 The bench SHALL cover this case: load 8'h00, i_up=0, one step -> o_bcd=99 and o_wrap pulse; the next step gives 98.
REQ-032 The bench SHALL cover this case: i_load with 8'hA7 -> o_bcd=07, and the prescaler restarts so the next o_tick comes 3 cycles later.
REQ-033 The bench SHALL cover this case: i_en=0 over 3 ticks -> o_bcd is unchanged, and o_tick keeps pulsing every 4 cycles.
REQ-034 The bench SHALL cover this case: o_bcd=05 in the LEAD_ZERO_BLANK_EN build -> o_seg=16'hFF92; without the macro -> 16'hC092.
